// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and protection-bit indices.
package axil_pkg;

   localparam int AXI_PROT_W = 3;

   typedef logic [AXI_PROT_W-1:0] axil_prot_t;

   localparam int PROT_PRIV  = 0;
   localparam int PROT_NSEC  = 1;
   localparam int PROT_INSTR = 2;

   // A beat is misaligned for a 32-bit register file when either low address bit is set.
   function automatic logic addr_misaligned(input logic [1:0] addr_lsb);
      return (addr_lsb != 2'b00);
   endfunction

endpackage

// File: rtl/axil_sync_fifo.sv
// Generic single-clock FIFO; pop data is combinational from the head slot, 1-cycle write-to-read.
// Pushes when full and pops when empty are dropped; occupancy drives full/empty.
module axil_sync_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                       ACLK,
   input  logic                       ARESETn,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic [$clog2(DEPTH):0]     count_next
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign pop_dat = mem[rd_ptr];

   always_comb begin
      count_next = count;
      case ({do_push, do_pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next;
      end
   end

endmodule

// File: rtl/axil_aw_channel_fifo.sv
// AXI4-Lite AW channel buffer; accepted beats reach o_awvalid one cycle later.
// AWREADY is registered !full, so space freed by a pop is offered on the following cycle.
module axil_aw_channel_fifo
   import axil_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DEPTH       = 4,
   parameter int ALIGN_CHECK = 1
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [ADDR_W-1:0]       AWADDR,
   input  axil_prot_t              AWPROT,
   output logic                    o_awvalid,
   input  logic                    i_awready,
   output logic [ADDR_W-1:0]       o_awaddr,
   output axil_prot_t              o_awprot,
   output logic                    o_misalign,
   output logic [$clog2(DEPTH):0]  o_count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int FW = ADDR_W + AXI_PROT_W + 1;

   logic          awready_q;
   logic          misalign_in;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [FW-1:0] head_dat;
   logic [CW-1:0] count_next;

   assign misalign_in = (ALIGN_CHECK != 0) && addr_misaligned(AWADDR[1:0]);
   assign push        = AWVALID && awready_q && !fifo_full;
   assign pop         = o_awvalid && i_awready;

   assign AWREADY   = awready_q;
   assign o_awvalid = !fifo_empty;
   assign {o_awaddr, o_awprot, o_misalign} = head_dat;

   axil_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .ACLK       (ACLK),
      .ARESETn    (ARESETn),
      .push       (push),
      .push_dat   ({AWADDR, AWPROT, misalign_in}),
      .pop        (pop),
      .pop_dat    (head_dat),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (o_count),
      .count_next (count_next)
   );

   // Ready looks at next-cycle occupancy so it never depends on AWVALID in the same cycle.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         awready_q <= 1'b0;
      end else begin
         awready_q <= (count_next < CW'(DEPTH));
      end
   end

endmodule
